// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: shared definitions for the float32 accumulator.
//   - FSM state encoding
//   - float32 field widths and the extended mantissa width
//     (hidden bit + 23 fraction bits + guard/round/sticky)
//   - special-value constants and unpack helpers
// Optional feature macro: FP_ACC_DENORM_EN (denormal inputs/results kept
// instead of flushed to a same-signed zero).
package fp_acc_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXT_W    = 27;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UNPACK,
    S_SPECIAL,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_t;

  function automatic logic is_nan(input logic [31:0] w);
    return (&w[30:23]) && (|w[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] w);
    return (&w[30:23]) && !(|w[22:0]);
  endfunction

  // Zero and denormal encodings share exponent 1 so that a zero operand
  // aligns like any other small value.
  function automatic logic [9:0] unpack_exp(input logic [31:0] w);
    return (w[30:23] == 8'd0) ? 10'd1 : {2'b00, w[30:23]};
  endfunction

  function automatic logic [EXT_W-1:0] unpack_man(input logic [31:0] w);
`ifdef FP_ACC_DENORM_EN
    return {(w[30:23] != 8'd0), w[22:0], 3'b000};
`else
    return (w[30:23] == 8'd0) ? '0 : {1'b1, w[22:0], 3'b000};
`endif
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even for a normalised
// (or minimum-exponent denormal) extended mantissa.
// Ports:
//   mant     in  27  {hidden, fraction[22:0], guard, round, sticky}
//   expo     in  10  biased exponent belonging to mant
//   man_rnd  out 23  rounded fraction field
//   exp_rnd  out 8   exponent field (0 when the rounded value is denormal)
//   ovf      out 1   rounded exponent reaches the inf/NaN encoding
module fp_round_rne
  import fp_acc_pkg::*;
(
  input  logic [EXT_W-1:0] mant,
  input  logic [9:0]       expo,
  output logic [MAN_W-1:0] man_rnd,
  output logic [EXP_W-1:0] exp_rnd,
  output logic             ovf
);

  logic        rnd_up;
  logic [24:0] m25;
  logic [9:0]  e_adj;
  logic        hid;

  always_comb begin
    rnd_up  = mant[2] & (mant[1] | mant[0] | mant[3]);
    m25     = {1'b0, mant[26:3]} + {24'd0, rnd_up};
    e_adj   = expo;
    hid     = m25[23];
    man_rnd = m25[22:0];
    // Mantissa carry: value became 1.000..0 x 2^(e+1)
    if (m25[24]) begin
      man_rnd = m25[23:1];
      e_adj   = expo + 10'd1;
      hid     = 1'b1;
    end
    exp_rnd = hid ? e_adj[7:0] : 8'd0;
    ovf     = hid && (e_adj >= 10'(EXP_MAX));
  end

endmodule

// File: rtl/fp_acc.sv
// fp_acc: IEEE-754 single-precision running-sum accumulator, acc += in_data,
// one alignment / normalisation bit per cycle. The total is emitted after
// the operand flagged in_last has been added, then acc returns to INIT_VALUE.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_data/in_last      operand and end-of-sum flag, captured on transfer
//   in_valid/in_ready    input handshake
//   out_data/out_valid   accumulated float32 result
//   out_ready            consumer accepts the result
// Optional feature macro: FP_ACC_DENORM_EN (see fp_acc_pkg).
module fp_acc
  import fp_acc_pkg::*;
#(
  parameter logic [31:0] INIT_VALUE = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t           state;
  logic [31:0]      acc;
  logic [31:0]      op_data;
  logic             op_last;
  logic             sa, sb;
  logic [9:0]       ea, eb;
  logic [EXT_W-1:0] ma, mb;
  logic [9:0]       diff;
  logic [EXT_W:0]   sum;
  logic             sign_r;
  logic [9:0]       exp_r;
  logic [31:0]      res;

  logic [MAN_W-1:0] man_rnd;
  logic [EXP_W-1:0] exp_rnd;
  logic             ovf;
  logic             flush;

  // Combinational so that it is high in the first cycle after reset release.
  assign in_ready = !rst && (state == S_IDLE) && !out_valid;

`ifdef FP_ACC_DENORM_EN
  assign flush = 1'b0;
`else
  assign flush = !sum[EXT_W-1];
`endif

  fp_round_rne u_round (
    .mant    (sum[EXT_W-1:0]),
    .expo    (exp_r),
    .man_rnd (man_rnd),
    .exp_rnd (exp_rnd),
    .ovf     (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= INIT_VALUE;
      op_data   <= '0;
      op_last   <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      ma        <= '0;
      mb        <= '0;
      diff      <= '0;
      sum       <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      res       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_data <= in_data;
            op_last <= in_last;
            state   <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sa    <= acc[31];
          ea    <= unpack_exp(acc);
          ma    <= unpack_man(acc);
          sb    <= op_data[31];
          eb    <= unpack_exp(op_data);
          mb    <= unpack_man(op_data);
          state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          if (is_nan(acc) || is_nan(op_data) ||
              (is_inf(acc) && is_inf(op_data) && (acc[31] != op_data[31]))) begin
            res   <= QNAN;
            state <= S_PACK;
          end else if (is_inf(acc)) begin
            res   <= acc;
            state <= S_PACK;
          end else if (is_inf(op_data)) begin
            res   <= op_data;
            state <= S_PACK;
          end else begin
            // Keep the larger exponent in the a-side; b is the one shifted.
            if (eb > ea) begin
              sa   <= sb;  ea <= eb;  ma <= mb;
              sb   <= sa;  eb <= ea;  mb <= ma;
              diff <= eb - ea;
            end else begin
              diff <= ea - eb;
            end
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (diff == 10'd0) begin
            state <= S_ADD;
          end else if (diff > 10'd26) begin
            mb    <= {{(EXT_W-1){1'b0}}, |mb};
            diff  <= '0;
            state <= S_ADD;
          end else begin
            mb   <= {1'b0, mb[EXT_W-1:2], mb[1] | mb[0]};
            diff <= diff - 10'd1;
          end
        end
        S_ADD: begin
          exp_r <= ea;
          if (sa == sb) begin
            sum    <= {1'b0, ma} + {1'b0, mb};
            sign_r <= sa;
          end else if (ma >= mb) begin
            sum    <= {1'b0, ma} - {1'b0, mb};
            sign_r <= (ma == mb) ? 1'b0 : sa;  // exact cancellation is +0
          end else begin
            sum    <= {1'b0, mb} - {1'b0, ma};
            sign_r <= sb;
          end
          state <= S_NORM;
        end
        S_NORM: begin
          if (sum[EXT_W]) begin
            sum   <= {1'b0, sum[EXT_W:2], sum[1] | sum[0]};
            exp_r <= exp_r + 10'd1;
          end else if (sum[EXT_W-1] || (sum == '0) || (exp_r <= 10'd1)) begin
            state <= S_ROUND;
          end else begin
            sum   <= {sum[EXT_W-1:0], 1'b0};
            exp_r <= exp_r - 10'd1;
          end
        end
        S_ROUND: begin
          if (ovf)
            res <= {sign_r, POS_INF[30:0]};
          else if (flush)
            res <= {sign_r, 31'd0};
          else
            res <= {sign_r, exp_rnd, man_rnd};
          state <= S_PACK;
        end
        S_PACK: begin
          if (op_last) begin
            out_data  <= res;
            out_valid <= 1'b1;
            acc       <= INIT_VALUE;
            state     <= S_DONE;
          end else begin
            acc   <= res;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc.sv
module tb_fp_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  fp_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [31:0] e;
  } vec_t;

  localparam int NV = 21;
  vec_t        tbl [0:NV-1];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

`ifdef FP_ACC_DENORM_EN
  localparam logic [31:0] DEN_EXP = 32'h00000002;
`else
  localparam logic [31:0] DEN_EXP = 32'h00000000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %08h want none", out_data);
      end else begin
        check("sum", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for %08h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int nout;

    tbl[0]  = '{32'h3F800000, 1'b0, 32'h0};
    tbl[1]  = '{32'h40000000, 1'b0, 32'h0};
    tbl[2]  = '{32'h40400000, 1'b1, 32'h40C00000};
    tbl[3]  = '{32'h3F800000, 1'b0, 32'h0};
    tbl[4]  = '{32'hBF800000, 1'b1, 32'h00000000};
    tbl[5]  = '{32'h7F800000, 1'b0, 32'h0};
    tbl[6]  = '{32'hFF800000, 1'b1, 32'h7FC00000};
    tbl[7]  = '{32'h7F800001, 1'b0, 32'h0};
    tbl[8]  = '{32'h3F800000, 1'b1, 32'h7FC00000};
    tbl[9]  = '{32'hC0400000, 1'b0, 32'h0};
    tbl[10] = '{32'h3F800000, 1'b1, 32'hC0000000};
    tbl[11] = '{32'h3FC00000, 1'b0, 32'h0};
    tbl[12] = '{32'hBF800000, 1'b1, 32'h3F000000};
    tbl[13] = '{32'h3F800000, 1'b0, 32'h0};
    tbl[14] = '{32'h33800000, 1'b1, 32'h3F800000};
    tbl[15] = '{32'h3F800001, 1'b0, 32'h0};
    tbl[16] = '{32'h33800000, 1'b1, 32'h3F800002};
    tbl[17] = '{32'h7F7FFFFF, 1'b0, 32'h0};
    tbl[18] = '{32'h7F7FFFFF, 1'b1, 32'h7F800000};
    tbl[19] = '{32'h00000001, 1'b0, 32'h0};
    tbl[20] = '{32'h00000001, 1'b1, DEN_EXP};

    rst       = 1'b1;
    in_data   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single operand, latency from transfer to out_valid.
    exp_q.push_back(32'h40400000);
    send(32'h40400000, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd7);
    wait_drain();

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].l) exp_q.push_back(tbl[i].e);
      send(tbl[i].d, tbl[i].l);
      if (tbl[i].l) wait_drain();
    end

    // Backpressure on the result.
    out_ready = 1'b0;
    exp_q.push_back(32'h40400000);
    send(32'h40400000, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_hold", out_data, 32'h40400000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drop", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(32'h40000000);
    send(32'h40000000, 1'b1);
    wait_drain();

    // Reset while the second operand is aligning; nothing must come out.
    send(32'h3F800000, 1'b0);
    send(32'h35800000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nout = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    check("abort_no_out", 32'(nout), 32'd0);
    exp_q.push_back(32'h40000000);
    send(32'h40000000, 1'b1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
